// File: rtl/stage4_mem.sv
// Pipeline stage 4 (MEM): holds one instruction, collects the data-SRAM load
// response, aligns/extends it and hands the result to WB and the ID bypass.
module stage4_mem #(
  parameter int unsigned SB_W = 118
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 es_to_ms_valid,
  output logic                 ms_allow_in,
  input  logic [31:0]          es_pc,
  input  logic [31:0]          es_result,
  input  logic [4:0]           es_dest,
  input  logic                 es_gr_we,
  input  logic [2:0]           es_ld_op,
  input  logic                 es_req_issued,
  input  logic [SB_W-1:0]      es_sb,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 ws_allow_in,
  input  logic                 wb_flush,
  output logic                 ms_to_ws_valid,
  output logic [70+SB_W-1:0]   ms_to_ws_bus,
  output logic                 ms_fwd_we,
  output logic [4:0]           ms_fwd_dest,
  output logic [31:0]          ms_fwd_data,
  output logic                 ms_ld_pending
);

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_B    = 3'b001,
    LD_H    = 3'b010,
    LD_W    = 3'b011,
    LD_BU   = 3'b101,
    LD_HU   = 3'b110
  } ld_op_e;

  logic              ms_valid_q, ms_valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       result_q, result_d;
  logic [4:0]        dest_q, dest_d;
  logic              gr_we_q, gr_we_d;
  logic [2:0]        ld_op_q, ld_op_d;
  logic              req_issued_q, req_issued_d;
  logic [SB_W-1:0]   sb_q, sb_d;
  logic              buf_valid_q, buf_valid_d;
  logic [31:0]       buf_q, buf_d;
  logic [1:0]        discard_q, discard_d;

  logic              is_load;
  logic              ld_wait;
  logic              data_ok_live;
  logic              ready_go;
  logic              capture;
  logic [31:0]       sel_data;
  logic [31:0]       byte_sh;
  logic [31:0]       half_sh;
  logic [31:0]       load_data;
  logic [31:0]       final_result;
  logic              pend_mem;
  logic              pend_ex;
  logic              discard_dec;
  logic [2:0]        discard_sum;

  assign is_load      = (ld_op_q != LD_NONE);
  assign ld_wait      = ms_valid_q & req_issued_q & is_load;
  // Responses owed to cancelled loads are swallowed while the discard count is non-zero.
  assign data_ok_live = data_sram_data_ok & (discard_q == 2'd0);
  assign ready_go     = ~ld_wait | buf_valid_q | data_ok_live;
  assign ms_allow_in  = ~ms_valid_q | (ready_go & ws_allow_in);
  assign capture      = ms_allow_in & es_to_ms_valid;

  assign ms_to_ws_valid = ms_valid_q & ready_go & ~wb_flush;

  assign sel_data = buf_valid_q ? buf_q : data_sram_rdata;
  assign byte_sh  = sel_data >> {result_q[1:0], 3'b000};
  assign half_sh  = sel_data >> {result_q[1], 4'b0000};

  always_comb begin
    load_data = sel_data;
    case (ld_op_q)
      LD_B:    load_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      LD_H:    load_data = {{16{half_sh[15]}}, half_sh[15:0]};
      LD_BU:   load_data = {24'd0, byte_sh[7:0]};
      LD_HU:   load_data = {16'd0, half_sh[15:0]};
      default: load_data = sel_data;
    endcase
  end

  assign final_result = (is_load & req_issued_q) ? load_data : result_q;

  assign ms_to_ws_bus  = {sb_q, final_result, dest_q, gr_we_q, pc_q};
  assign ms_fwd_we     = ms_valid_q & gr_we_q;
  assign ms_fwd_dest   = dest_q;
  assign ms_fwd_data   = final_result;
  assign ms_ld_pending = ms_valid_q & is_load & ~ready_go;

  // A flush cancels the waiting MEM load (unless its data arrives this very
  // cycle) and any request EX issued this cycle; each leaves one response to drop.
  assign pend_mem    = wb_flush & ld_wait & ~buf_valid_q & ~data_ok_live;
  assign pend_ex     = wb_flush & es_req_issued & es_to_ms_valid;
  assign discard_dec = data_sram_data_ok & (discard_q != 2'd0);
  assign discard_sum = {1'b0, discard_q} + {2'b00, pend_mem} + {2'b00, pend_ex}
                       - {2'b00, discard_dec};

  always_comb begin
    ms_valid_d   = ms_valid_q;
    pc_d         = pc_q;
    result_d     = result_q;
    dest_d       = dest_q;
    gr_we_d      = gr_we_q;
    ld_op_d      = ld_op_q;
    req_issued_d = req_issued_q;
    sb_d         = sb_q;
    buf_valid_d  = buf_valid_q;
    buf_d        = buf_q;
    discard_d    = (discard_sum > 3'd3) ? 2'd3 : discard_sum[1:0];

    if (ms_allow_in) begin
      ms_valid_d  = es_to_ms_valid;
      buf_valid_d = 1'b0;
    end
    if (capture) begin
      pc_d         = es_pc;
      result_d     = es_result;
      dest_d       = es_dest;
      gr_we_d      = es_gr_we;
      ld_op_d      = es_ld_op;
      req_issued_d = es_req_issued;
      sb_d         = es_sb;
    end

    if (ld_wait & ~buf_valid_q & data_ok_live & ~ws_allow_in) begin
      buf_d       = data_sram_rdata;
      buf_valid_d = 1'b1;
    end

    if (wb_flush) begin
      ms_valid_d  = 1'b0;
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      pc_q         <= '0;
      result_q     <= '0;
      dest_q       <= '0;
      gr_we_q      <= 1'b0;
      ld_op_q      <= '0;
      req_issued_q <= 1'b0;
      sb_q         <= '0;
      buf_valid_q  <= 1'b0;
      buf_q        <= '0;
      discard_q    <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      pc_q         <= pc_d;
      result_q     <= result_d;
      dest_q       <= dest_d;
      gr_we_q      <= gr_we_d;
      ld_op_q      <= ld_op_d;
      req_issued_q <= req_issued_d;
      sb_q         <= sb_d;
      buf_valid_q  <= buf_valid_d;
      buf_q        <= buf_d;
      discard_q    <= discard_d;
    end
  end

endmodule

// File: tb/tb_stage4_mem.sv
// Directed bench for stage4_mem: pass-through, load wait/align, buffering,
// flush-driven response discard and asynchronous reset.
module tb_stage4_mem;

  localparam int unsigned SB_W = 118;

  logic               clk = 1'b0;
  logic               reset;
  logic               es_to_ms_valid;
  logic               ms_allow_in;
  logic [31:0]        es_pc;
  logic [31:0]        es_result;
  logic [4:0]         es_dest;
  logic               es_gr_we;
  logic [2:0]         es_ld_op;
  logic               es_req_issued;
  logic [SB_W-1:0]    es_sb;
  logic               data_sram_data_ok;
  logic [31:0]        data_sram_rdata;
  logic               ws_allow_in;
  logic               wb_flush;
  logic               ms_to_ws_valid;
  logic [70+SB_W-1:0] ms_to_ws_bus;
  logic               ms_fwd_we;
  logic [4:0]         ms_fwd_dest;
  logic [31:0]        ms_fwd_data;
  logic               ms_ld_pending;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  stage4_mem #(.SB_W(SB_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allow_in       (ms_allow_in),
    .es_pc             (es_pc),
    .es_result         (es_result),
    .es_dest           (es_dest),
    .es_gr_we          (es_gr_we),
    .es_ld_op          (es_ld_op),
    .es_req_issued     (es_req_issued),
    .es_sb             (es_sb),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allow_in       (ws_allow_in),
    .wb_flush          (wb_flush),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_fwd_we         (ms_fwd_we),
    .ms_fwd_dest       (ms_fwd_dest),
    .ms_fwd_data       (ms_fwd_data),
    .ms_ld_pending     (ms_ld_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] d,
                       input logic we, input logic [2:0] op, input logic req);
    es_to_ms_valid = 1'b1;
    es_pc          = pc;
    es_result      = res;
    es_dest        = d;
    es_gr_we       = we;
    es_ld_op       = op;
    es_req_issued  = req;
  endtask

  task automatic idle();
    es_to_ms_valid = 1'b0;
    es_req_issued  = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_pc             = '0;
    es_result         = '0;
    es_dest           = '0;
    es_gr_we          = 1'b0;
    es_ld_op          = '0;
    es_req_issued     = 1'b0;
    es_sb             = '0;
    es_sb[63:0]       = 64'hCAFE_F00D_1234_5678;
    es_sb[117:100]    = 18'h2AAAA;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    ws_allow_in       = 1'b1;
    wb_flush          = 1'b0;

    // Reset state
    #2;
    chk("rst_valid",   64'(ms_to_ws_valid), 64'd0);
    chk("rst_fwd_we",  64'(ms_fwd_we), 64'd0);
    chk("rst_pending", 64'(ms_ld_pending), 64'd0);
    chk("rst_allow",   64'(ms_allow_in), 64'd1);
    chk("rst_bus_lo",  ms_to_ws_bus[63:0], 64'd0);
    tick(); tick();
    reset = 1'b0;

    // 1: plain ALU op passes through in one cycle
    offer(32'h1C00_0010, 32'h0000_1234, 5'd4, 1'b1, 3'b000, 1'b0);
    #1 chk("t1_allow", 64'(ms_allow_in), 64'd1);
    tick(); idle();
    #1;
    chk("t1_valid",   64'(ms_to_ws_valid), 64'd1);
    chk("t1_result",  64'(ms_to_ws_bus[69:38]), 64'h1234);
    chk("t1_dest",    64'(ms_to_ws_bus[37:33]), 64'd4);
    chk("t1_gr_we",   64'(ms_to_ws_bus[32]), 64'd1);
    chk("t1_pc",      64'(ms_to_ws_bus[31:0]), 64'h1C00_0010);
    chk("t1_sb_lo",   ms_to_ws_bus[133:70], 64'hCAFE_F00D_1234_5678);
    chk("t1_sb_hi",   64'(ms_to_ws_bus[187:170]), 64'h2AAAA);
    chk("t1_fwd_we",  64'(ms_fwd_we), 64'd1);
    chk("t1_fwd_dst", 64'(ms_fwd_dest), 64'd4);
    chk("t1_fwd_dat", 64'(ms_fwd_data), 64'h1234);
    chk("t1_pending", 64'(ms_ld_pending), 64'd0);
    tick();
    #1 chk("t1_drain", 64'(ms_to_ws_valid), 64'd0);

    // 2: ld.b at byte 3, response three cycles late
    offer(32'h1C00_0014, 32'h0000_1003, 5'd5, 1'b1, 3'b001, 1'b1);
    tick(); idle();
    #1;
    chk("t2_pend_c1", 64'(ms_ld_pending), 64'd1);
    chk("t2_allow",   64'(ms_allow_in), 64'd0);
    chk("t2_valid_w", 64'(ms_to_ws_valid), 64'd0);
    tick();
    #1 chk("t2_pend_c2", 64'(ms_ld_pending), 64'd1);
    tick();
    #1 chk("t2_pend_c3", 64'(ms_ld_pending), 64'd1);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_FFFF;
    #1;
    chk("t2_pend_ok", 64'(ms_ld_pending), 64'd0);
    chk("t2_valid",   64'(ms_to_ws_valid), 64'd1);
    chk("t2_result",  64'(ms_to_ws_bus[69:38]), 64'hFFFF_FF80);
    chk("t2_fwd_dat", 64'(ms_fwd_data), 64'hFFFF_FF80);
    tick();
    data_sram_data_ok = 1'b0;
    #1 chk("t2_drain", 64'(ms_to_ws_valid), 64'd0);

    // 3: ld.hu at halfword 2, WB stalled when data arrives -> buffered
    offer(32'h1C00_0018, 32'h0000_2002, 5'd6, 1'b1, 3'b110, 1'b1);
    ws_allow_in = 1'b0;
    tick(); idle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBEEF_1234;
    #1;
    chk("t3_valid_ok", 64'(ms_to_ws_valid), 64'd1);
    chk("t3_allow_ok", 64'(ms_allow_in), 64'd0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0000_0000;
    #1;
    chk("t3_buf_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("t3_buf_res",   64'(ms_to_ws_bus[69:38]), 64'h0000_BEEF);
    chk("t3_buf_pend",  64'(ms_ld_pending), 64'd0);
    chk("t3_buf_allow", 64'(ms_allow_in), 64'd0);
    ws_allow_in = 1'b1;
    #1 chk("t3_allow", 64'(ms_allow_in), 64'd1);
    tick();
    #1 chk("t3_drain", 64'(ms_to_ws_valid), 64'd0);

    // 4: flush a waiting ld.w; its late response 0xDEAD is dropped
    offer(32'h1C00_001C, 32'h0000_3000, 5'd7, 1'b1, 3'b011, 1'b1);
    tick(); idle();
    wb_flush = 1'b1;
    #1 chk("t4_flush_valid", 64'(ms_to_ws_valid), 64'd0);
    tick();
    wb_flush = 1'b0;
    #1 chk("t4_fwd_we", 64'(ms_fwd_we), 64'd0);
    offer(32'h1C00_0020, 32'h0000_4000, 5'd8, 1'b1, 3'b011, 1'b1);
    tick(); idle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_DEAD;
    #1;
    chk("t4_drop_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("t4_drop_pend",  64'(ms_ld_pending), 64'd1);
    tick();
    data_sram_rdata = 32'h0000_0005;
    #1;
    chk("t4_valid",  64'(ms_to_ws_valid), 64'd1);
    chk("t4_result", 64'(ms_to_ws_bus[69:38]), 64'h5);
    chk("t4_dest",   64'(ms_to_ws_bus[37:33]), 64'd8);
    tick();
    data_sram_data_ok = 1'b0;

    // 5: flush and data_ok together -> nothing delivered, nothing to discard
    offer(32'h1C00_0024, 32'h0000_5000, 5'd9, 1'b1, 3'b011, 1'b1);
    tick(); idle();
    wb_flush          = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0077;
    #1 chk("t5_flush_valid", 64'(ms_to_ws_valid), 64'd0);
    tick();
    wb_flush          = 1'b0;
    data_sram_data_ok = 1'b0;
    #1 chk("t5_after_valid", 64'(ms_to_ws_valid), 64'd0);
    offer(32'h1C00_0028, 32'h0000_5004, 5'd10, 1'b1, 3'b011, 1'b1);
    tick(); idle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0099;
    #1;
    chk("t5_next_valid",  64'(ms_to_ws_valid), 64'd1);
    chk("t5_next_result", 64'(ms_to_ws_bus[69:38]), 64'h99);
    tick();
    data_sram_data_ok = 1'b0;

    // Alignment boundaries: ld.h at 0 (sign), ld.bu at 1, unissued misaligned ld.h
    offer(32'h1C00_002C, 32'h0000_6000, 5'd11, 1'b1, 3'b010, 1'b1);
    tick(); idle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_8001;
    #1 chk("ldh_a0", 64'(ms_to_ws_bus[69:38]), 64'hFFFF_8001);
    tick();
    data_sram_data_ok = 1'b0;
    offer(32'h1C00_0030, 32'h0000_6001, 5'd12, 1'b1, 3'b101, 1'b1);
    tick(); idle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_9A00;
    #1 chk("ldbu_a1", 64'(ms_to_ws_bus[69:38]), 64'h0000_009A);
    tick();
    data_sram_data_ok = 1'b0;
    offer(32'h1C00_0034, 32'h0000_7001, 5'd13, 1'b1, 3'b010, 1'b0);
    tick(); idle();
    #1;
    chk("ale_valid",  64'(ms_to_ws_valid), 64'd1);
    chk("ale_result", 64'(ms_to_ws_bus[69:38]), 64'h7001);
    chk("ale_pend",   64'(ms_ld_pending), 64'd0);
    tick();

    // 6: reset while waiting with a non-zero discard count
    offer(32'h1C00_0038, 32'h0000_8000, 5'd14, 1'b1, 3'b011, 1'b1);
    tick(); idle();
    wb_flush = 1'b1;
    tick();
    wb_flush = 1'b0;
    offer(32'h1C00_003C, 32'h0000_8004, 5'd15, 1'b1, 3'b011, 1'b1);
    tick(); idle();
    #1 chk("t6_pend_before", 64'(ms_ld_pending), 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid",  64'(ms_to_ws_valid), 64'd0);
    chk("t6_rst_pend",   64'(ms_ld_pending), 64'd0);
    chk("t6_rst_fwd_we", 64'(ms_fwd_we), 64'd0);
    chk("t6_rst_pc",     64'(ms_to_ws_bus[31:0]), 64'd0);
    chk("t6_rst_allow",  64'(ms_allow_in), 64'd1);
    tick();
    reset = 1'b0;
    offer(32'h1C00_0040, 32'h0000_8008, 5'd16, 1'b1, 3'b011, 1'b1);
    tick(); idle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_00AB;
    #1;
    chk("t6_post_valid",  64'(ms_to_ws_valid), 64'd1);
    chk("t6_post_result", 64'(ms_to_ws_bus[69:38]), 64'hAB);
    tick();
    data_sram_data_ok = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
